// File: rtl/blink_sequencer_if.sv
// Host-side write port for the blink_sequencer pattern table.
// The host drives the master side; the sequencer samples the slave side.
interface blink_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              CFG_WE;
   logic [ADDR_W-1:0] CFG_ADDR;
   logic [7:0]        CFG_DATA;

   modport master (output CFG_WE, CFG_ADDR, CFG_DATA);
   modport slave  (input  CFG_WE, CFG_ADDR, CFG_DATA);
endinterface

// File: rtl/blink_sequencer.sv
// Table-driven RGB LED sequencer: a run/pause FSM steps through a writable
// pattern table, holding each entry for (dur+1) prescaler ticks.
module blink_sequencer #(
   parameter int TICK_W = 26,
   parameter int PAT_W  = 1,
   parameter int STEP_W = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             BTN_RUN,
   input  logic             BTN_NEXT,
   blink_sequencer_if.slave cfg,
   output logic [2:0]       LED_RGB,
   output logic             RUNNING,
   output logic [PAT_W-1:0] PAT,
   output logic             PAT_WRAP
);
   localparam int ADDR_W = PAT_W + STEP_W;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW, S_PAUSE} state_e;

   typedef struct packed {
      logic       last;
      logic [3:0] dur;
      logic [2:0] rgb;
   } entry_t;

   function automatic entry_t default_entry(input int idx);
      int     pat_i;
      int     step_i;
      entry_t e;
      pat_i  = idx / (1 << STEP_W);
      step_i = idx % (1 << STEP_W);
      e      = '{last: 1'b1, dur: 4'd0, rgb: 3'b000};
      if (pat_i < 2 && step_i < 5) begin
         e.last = (step_i == 4);
         if (pat_i == 0) begin
            case (step_i)
               0:       e.rgb = 3'b100;
               1:       e.rgb = 3'b010;
               2:       e.rgb = 3'b001;
               3:       e.rgb = 3'b111;
               default: e.rgb = 3'b000;
            endcase
         end else begin
            case (step_i)
               0:       e.rgb = 3'b110;
               1:       e.rgb = 3'b011;
               2:       e.rgb = 3'b101;
               3:       e.rgb = 3'b111;
               default: e.rgb = 3'b000;
            endcase
         end
      end
      return e;
   endfunction

   state_e              state_q,  state_d;
   logic [PAT_W-1:0]    pat_q,    pat_d;
   logic [STEP_W-1:0]   step_q,   step_d;
   logic [TICK_W-1:0]   presc_q,  presc_d;
   logic [3:0]          dur_q,    dur_d;
   logic [2:0]          led_q,    led_d;
   logic                wrap_q,   wrap_d;
   entry_t              table_q [DEPTH];
   entry_t              table_d [DEPTH];

   logic                tick;
   logic                seq_wrap;
   logic [STEP_W-1:0]   step_adv;
   logic [ADDR_W-1:0]   adv_addr;
   logic [ADDR_W-1:0]   load_addr;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves
      // a value unassigned and no latch is inferred.
      state_d   = state_q;
      pat_d     = pat_q;
      step_d    = step_q;
      presc_d   = presc_q;
      dur_d     = dur_q;
      led_d     = led_q;
      wrap_d    = 1'b0;
      table_d   = table_q;

      tick      = (presc_q == '1);
      seq_wrap  = table_q[{pat_q, step_q}].last || (step_q == '1);
      step_adv  = seq_wrap ? '0 : step_q + 1'b1;
      adv_addr  = {pat_q, step_adv};
      load_addr = {pat_q, {STEP_W{1'b0}}};

      if (cfg.CFG_WE) begin
         table_d[cfg.CFG_ADDR] = cfg.CFG_DATA;
      end

      case (state_q)
         S_IDLE: begin
            led_d   = 3'b000;
            presc_d = '0;
            if (BTN_NEXT) begin
               pat_d = pat_q + 1'b1;
            end else if (BTN_RUN) begin
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            if (BTN_NEXT) begin
               pat_d = pat_q + 1'b1;
            end else begin
               led_d   = table_q[load_addr].rgb;
               dur_d   = table_q[load_addr].dur;
               presc_d = '0;
               step_d  = '0;
               state_d = S_SHOW;
            end
         end

         S_SHOW: begin
            if (BTN_NEXT) begin
               pat_d   = pat_q + 1'b1;
               step_d  = '0;
               state_d = S_LOAD;
            end else begin
               // The prescaler rolls over to 0 on the tick, so the next step
               // starts with no gap.
               presc_d = presc_q + 1'b1;
               if (tick) begin
                  if (dur_q != 4'd0) begin
                     dur_d = dur_q - 1'b1;
                  end else begin
                     step_d = step_adv;
                     led_d  = table_q[adv_addr].rgb;
                     dur_d  = table_q[adv_addr].dur;
                     wrap_d = seq_wrap;
                  end
               end
               if (BTN_RUN) begin
                  state_d = S_PAUSE;
               end
            end
         end

         S_PAUSE: begin
            if (BTN_NEXT) begin
               pat_d   = pat_q + 1'b1;
               step_d  = '0;
               state_d = S_LOAD;
            end else if (BTN_RUN) begin
               state_d = S_SHOW;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the values computed before this edge, independent of statement order.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         step_q  <= '0;
         presc_q <= '0;
         dur_q   <= '0;
         led_q   <= 3'b000;
         wrap_q  <= 1'b0;
         // NOTE: the table is a register array, not RAM, precisely so reset can
         // restore the default patterns.
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= default_entry(i);
         end
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         step_q  <= step_d;
         presc_q <= presc_d;
         dur_q   <= dur_d;
         led_q   <= led_d;
         wrap_q  <= wrap_d;
         table_q <= table_d;
      end
   end

   assign LED_RGB  = led_q;
   assign PAT      = pat_q;
   assign PAT_WRAP = wrap_q;
   assign RUNNING  = (state_q == S_LOAD) || (state_q == S_SHOW);

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
Table-driven controller that sequences the RGB LED through programmable colour patterns. It replaces the fixed 5-step LED counter and colour decoder with a small pattern table, a run/pause state machine and a per-step duration scheduler. It takes debounced single-cycle button pulses from the existing debounce block and drives LED_RGB directly. A host-side write port reprograms the table at run time.

Parameters:
TICK_W, 26, prescaler width; one tick every 2^TICK_W cycles while showing.
PAT_W, 1, pattern-select width; number of patterns = 2^PAT_W.
STEP_W, 3, step-index width; steps per pattern = 2^STEP_W; table depth = 2^(PAT_W+STEP_W).

Ports:
CLK  in  1  system clock; all logic on posedge.
RST  in  1  reset; synchronous, active-low (0 = reset).
BTN_RUN  in  1  debounced 1-cycle pulse: start / pause / resume.
BTN_NEXT  in  1  debounced 1-cycle pulse: select next pattern.
CFG_WE  in  1  table write enable.
CFG_ADDR  in  PAT_W+STEP_W  table address = {pattern, step}.
CFG_DATA  in  8  entry {last[7], dur[6:3], rgb[2:0]}.
LED_RGB  out  3  registered LED drive {R,G,B}.
RUNNING  out  1  1 in LOAD or SHOW.
PAT  out  PAT_W  currently selected pattern.
PAT_WRAP  out  1  1-cycle pulse when the sequence wraps to step 0.

Behaviour:
- Reset (RST=0 at posedge): state IDLE, LED_RGB=000, PAT=0, step=0, prescaler=0, dur counter=0, PAT_WRAP=0, RUNNING=0.
- Reset loads the default table (PAT_W=1, STEP_W=3). Entries not listed are {last=1, dur=0, rgb=000}.
  - Pattern 0, steps 0-4: rgb 100, 010, 001, 111, 000; step 4 has last=1; all dur=0.
  - Pattern 1, steps 0-4: rgb 110, 011, 101, 111, 000; step 4 has last=1; all dur=0.
- Table is a register array. CFG_WE writes CFG_DATA to CFG_ADDR at the posedge, in any state. A write to the currently displayed entry does not alter LED_RGB; it takes effect the next time that entry is fetched.
- States:
  - IDLE: LED_RGB=000, prescaler held at 0. BTN_RUN -> LOAD.
  - LOAD: one cycle. Fetches entry {PAT, step=0}: LED_RGB<=rgb, dur counter<=dur, prescaler<=0. Always -> SHOW.
  - SHOW: prescaler increments each cycle; tick when prescaler == all-ones.
    - On a tick with dur counter != 0: decrement dur counter.
    - On a tick with dur counter == 0 (step end): advance the step.
    - Advance wraps to step 0 and pulses PAT_WRAP for 1 cycle if the current entry has last=1 or step == 2^STEP_W-1; otherwise step+1.
    - The next entry is fetched in the same cycle: LED_RGB, dur counter and prescaler (wraps to 0) update at that posedge.
    - BTN_RUN -> PAUSE.
  - PAUSE: LED_RGB, step, prescaler and dur counter frozen. BTN_RUN -> SHOW, resuming the remaining time exactly.
- Step length is exactly (dur+1)*2^TICK_W cycles, with no gap between steps. LED_RGB first shows step 0 two posedges after the BTN_RUN pulse.
- BTN_NEXT: PAT<=PAT+1, wrapping modulo 2^PAT_W.
  - In SHOW or PAUSE: step<=0, state -> LOAD.
  - In IDLE or LOAD: state unchanged; the new PAT is used by the next LOAD. A BTN_NEXT in LOAD re-enters LOAD.
- BTN_NEXT and BTN_RUN in the same cycle: BTN_NEXT is processed and BTN_RUN is ignored.
- Step end coinciding with BTN_RUN in SHOW: the step advance happens and the state becomes PAUSE, showing the new entry.
- Step end coinciding with BTN_NEXT: BTN_NEXT wins; no PAT_WRAP pulse.
- Reset mid-sequence returns to the reset values above on the next posedge, including the default table contents.
- All arithmetic is unsigned and wraps modulo its field width.

Test Plan:
1. TICK_W=2, reset released, BTN_RUN pulse at cycle n -> LED_RGB=100 from n+2 for 4 cycles, then 010, 001, 111, 000 (4 cycles each). Then 100 again, with PAT_WRAP=1 in the cycle LED_RGB returns to 100.
2. TICK_W=2, step 1 shown for 2 cycles, BTN_RUN -> LED_RGB frozen at 010 for 10 cycles. Second BTN_RUN -> 010 held for exactly 2 more cycles, then 001.
3. Running pattern 0, BTN_NEXT -> PAT=1, one LOAD cycle, then LED_RGB=110 for 4 cycles. PAT_WRAP stays 0 across the switch.
4. CFG_WE writes {last=1, dur=2, rgb=011} at address 0x01 while step 0 is shown -> LED sequence 100 (4 cycles), 011 (12 cycles), then wrap to 100 with a PAT_WRAP pulse.
5. BTN_NEXT and BTN_RUN asserted together in IDLE -> PAT=1, state stays IDLE, LED_RGB=000. Next lone BTN_RUN starts pattern 1 (110).
6. RST=0 for one cycle during SHOW of step 3 -> next cycle LED_RGB=000, RUNNING=0, PAT=0. Any prior table writes revert to defaults.
